intra16_pred: RTL
=================

# intra16_pred

Luma 16x16 intra-prediction generator for the macroblock encoder. It sits directly downstream of the boundary-save stage and consumes that stage's top row, left column and top-left luma samples. On each start pulse it latches the boundary and computes the four 16x16 candidates: DC, TM, VE and HE. It streams them one 16-pixel row per beat over a valid/ready interface to the mode-decision/residual stage.

## Interface
- none: no parameters; block size is fixed at 16.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request; sampled only in IDLE
- has_top  in  1  top neighbour exists (macroblock row > 0)
- has_left  in  1  left neighbour exists (macroblock column > 0)
- top_y  in  160  top row; byte i = column i, bits [8i+7:8i]; only [127:0] used
- left_y  in  128  left column; byte j = row j
- top_left_y  in  8  top-left corner sample
- busy  out  1  high from the cycle after start acceptance until the final beat is accepted
- pred_valid  out  1  beat valid
- pred_ready  in  1  downstream accept
- pred_mode  out  2  0=DC, 1=TM, 2=VE, 3=HE
- pred_row  out  4  row index 0..15 within the current mode
- pred_data  out  128  16 predicted pixels; byte i = column i
- pred_last  out  1  high on beat (mode 3, row 15)
- done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- Reset: state IDLE; busy, pred_valid, pred_last, done = 0; pred_mode, pred_row, pred_data = 0; all latched registers = 0.
- State machine:
  - IDLE: on start, latch top_y[127:0], left_y, top_left_y, has_top and has_left, then go to CALC.
  - CALC: one cycle; compute the DC value; go to EMIT with mode=0, row=0.
  - EMIT: present beats. On each handshake (pred_valid & pred_ready) advance row. At row 15, advance mode and reset row to 0. The handshake at mode 3 / row 15 goes to IDLE and pulses done.
- Inputs other than pred_ready are ignored outside IDLE. start while busy is dropped, with no queueing.
- DC (13-bit sum S):
  - Both neighbours present: S = Σtop + Σleft.
  - Top only: S = 2·Σtop.
  - Left only: S = 2·Σleft.
  - Neither: DC = 0x80.
  - Otherwise DC = (S + 16) >> 5.
  - Every byte of every DC row equals DC.
- TM: pixel(row r, col c) = clip255(top[c] + left[r] − top_left), evaluated as signed 10-bit; results <0 become 0, results >255 become 255. Computed combinationally per row from the latched registers. TM is always computed from the latched samples regardless of the has_* flags; the upstream stage supplies the 127/129 substitutes.
- VE: every row equals the latched top[127:0].
- HE: row r is 16 copies of left byte r.
- pred_data, pred_mode, pred_row and pred_last are registered outputs.

## Timing
- start accepted at cycle T → busy=1 from T+1; CALC occupies T+1; first beat (DC, row 0) is valid at T+2.
- With pred_ready held high: one beat per cycle, 64 beats; the last beat is at T+65; done=1 and busy=0 at T+66.
- Back-pressure: while pred_valid & !pred_ready, all pred_* outputs stay stable. pred_valid never drops without a handshake.
- pred_valid is continuously high in EMIT; there are no bubbles between modes.
- done and busy=0 are coincident. A start in the done cycle is accepted, giving back-to-back macroblocks with a 2-cycle gap (IDLE and CALC).
- rst_n asserted mid-stream clears immediately to the reset values with no done pulse. The first start after release behaves as from power-up.
- Latched boundary changes only on start acceptance; input changes during EMIT do not affect output.

## Test plan
- Top all 10, left all 20, both flags set → DC beats all 0x0F (480+16>>5=15); VE rows all 0x0A; HE rows all 0x14; TM = 10+20−tl.
- has_top=1, has_left=0, top all 10 → DC = 0x0A ((320+16)>>5). With both flags 0 → DC rows all 0x80.
- TM clipping: top=250, left=250, tl=10 → all TM bytes 255. Top=5, left=5, tl=200 → all 0. Mixed ramp top[c]=c, left[r]=16r, tl=0 → TM(r,c)=16r+c.
- Random pred_ready (50% duty) → exactly 64 handshakes, in order (mode, row) = (0,0)…(3,15). Outputs are stable during stalls; pred_last appears only on the final beat; one done pulse.
- start pulsed at T+10 while busy → ignored: the beat count stays 64 and the latched data is unchanged. start in the done cycle → second sequence begins, with its first valid 2 cycles later.
- rst_n low at beat 20 → all outputs 0 the same cycle, no done pulse; a new start afterwards produces a correct full 64-beat sequence.

Source files
------------

// File: rtl/intra16_pred.sv
// Luma 16x16 intra-prediction generator: latches the macroblock boundary on start,
// then streams DC, TM, VE and HE candidates one 16-pixel row per valid/ready beat.
module intra16_pred (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         has_top,
  input  logic         has_left,
  input  logic [159:0] top_y,
  input  logic [127:0] left_y,
  input  logic [7:0]   top_left_y,
  output logic         busy,
  output logic         pred_valid,
  input  logic         pred_ready,
  output logic [1:0]   pred_mode,
  output logic [3:0]   pred_row,
  output logic [127:0] pred_data,
  output logic         pred_last,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_EMIT = 2'd2
  } state_e;

  localparam logic [1:0] MODE_DC = 2'd0;
  localparam logic [1:0] MODE_TM = 2'd1;
  localparam logic [1:0] MODE_VE = 2'd2;
  localparam logic [1:0] MODE_HE = 2'd3;

  state_e         state_q, state_d;
  logic [127:0]   top_q, left_q;
  logic [7:0]     tl_q;
  logic           has_top_q, has_left_q;
  logic [7:0]     dc_q, dc_d;
  logic           latch_en;

  logic           pred_valid_q, pred_valid_d;
  logic [1:0]     pred_mode_q, pred_mode_d;
  logic [3:0]     pred_row_q, pred_row_d;
  logic [127:0]   pred_data_q, pred_data_d;
  logic           pred_last_q, pred_last_d;
  logic           done_q, done_d;

  logic [11:0]    sum_top, sum_left;
  logic [12:0]    dc_sum, dc_rnd;
  logic [7:0]     dc_calc;
  logic [5:0]     nxt_beat;
  logic [1:0]     nxt_mode;
  logic [3:0]     nxt_row;
  logic [7:0]     left_px;
  logic [127:0]   row_data;
  logic           fire;

  // Only the low 16 bytes of the top row carry samples.
  logic           unused_top_hi;
  assign unused_top_hi = ^top_y[159:128];

  // top + left - top_left spans -255..510, so 10 signed bits hold it exactly.
  function automatic logic [7:0] tm_pixel(input logic [7:0] t, input logic [7:0] l,
                                          input logic [7:0] tl);
    logic signed [9:0] v;
    v = signed'({2'b00, t}) + signed'({2'b00, l}) - signed'({2'b00, tl});
    if (v < 10'sd0)        return 8'h00;
    else if (v > 10'sd255) return 8'hFF;
    else                   return v[7:0];
  endfunction

  // NOTE: every variable driven here gets a value before any branch, so no latch is inferred.
  always_comb begin
    sum_top  = '0;
    sum_left = '0;
    for (int i = 0; i < 16; i++) begin
      sum_top  = sum_top  + 12'(top_q[8*i +: 8]);
      sum_left = sum_left + 12'(left_q[8*i +: 8]);
    end
    case ({has_top_q, has_left_q})
      2'b11:   dc_sum = {1'b0, sum_top} + {1'b0, sum_left};
      2'b10:   dc_sum = {sum_top, 1'b0};
      2'b01:   dc_sum = {sum_left, 1'b0};
      default: dc_sum = '0;
    endcase
    // Max sum 8160 + 16 still fits 13 bits.
    dc_rnd  = dc_sum + 13'd16;
    dc_calc = (has_top_q | has_left_q) ? dc_rnd[12:5] : 8'h80;
  end

  // Row content for the beat that follows the one currently presented.
  always_comb begin
    nxt_beat = {pred_mode_q, pred_row_q} + 6'd1;
    nxt_mode = nxt_beat[5:4];
    nxt_row  = nxt_beat[3:0];
    left_px  = left_q[{nxt_row, 3'b000} +: 8];
    row_data = '0;
    case (nxt_mode)
      MODE_DC: row_data = {16{dc_q}};
      MODE_TM: begin
        for (int c = 0; c < 16; c++) begin
          row_data[8*c +: 8] = tm_pixel(top_q[8*c +: 8], left_px, tl_q);
        end
      end
      MODE_VE: row_data = top_q;
      MODE_HE: row_data = {16{left_px}};
      default: row_data = '0;
    endcase
  end

  assign fire = pred_valid_q & pred_ready;

  always_comb begin
    state_d      = state_q;
    latch_en     = 1'b0;
    dc_d         = dc_q;
    pred_valid_d = pred_valid_q;
    pred_mode_d  = pred_mode_q;
    pred_row_d   = pred_row_q;
    pred_data_d  = pred_data_q;
    pred_last_d  = pred_last_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          latch_en = 1'b1;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        dc_d         = dc_calc;
        pred_valid_d = 1'b1;
        pred_mode_d  = MODE_DC;
        pred_row_d   = 4'd0;
        pred_data_d  = {16{dc_calc}};
        pred_last_d  = 1'b0;
        state_d      = S_EMIT;
      end
      S_EMIT: begin
        if (fire) begin
          if (pred_last_q) begin
            state_d      = S_IDLE;
            pred_valid_d = 1'b0;
            pred_mode_d  = '0;
            pred_row_d   = '0;
            pred_data_d  = '0;
            pred_last_d  = 1'b0;
            done_d       = 1'b1;
          end else begin
            pred_mode_d = nxt_mode;
            pred_row_d  = nxt_row;
            pred_data_d = row_data;
            pred_last_d = (nxt_beat == 6'h3F);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      dc_q         <= '0;
      pred_valid_q <= 1'b0;
      pred_mode_q  <= '0;
      pred_row_q   <= '0;
      pred_data_q  <= '0;
      pred_last_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dc_q         <= dc_d;
      pred_valid_q <= pred_valid_d;
      pred_mode_q  <= pred_mode_d;
      pred_row_q   <= pred_row_d;
      pred_data_q  <= pred_data_d;
      pred_last_q  <= pred_last_d;
      done_q       <= done_d;
    end
  end

  // NOTE: the boundary registers are reset too, so a stream after reset never sees stale samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q      <= '0;
      left_q     <= '0;
      tl_q       <= '0;
      has_top_q  <= 1'b0;
      has_left_q <= 1'b0;
    end else if (latch_en) begin
      top_q      <= top_y[127:0];
      left_q     <= left_y;
      tl_q       <= top_left_y;
      has_top_q  <= has_top;
      has_left_q <= has_left;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign pred_valid = pred_valid_q;
  assign pred_mode  = pred_mode_q;
  assign pred_row   = pred_row_q;
  assign pred_data  = pred_data_q;
  assign pred_last  = pred_last_q;
  assign done       = done_q;

endmodule
